// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - two-stage pipelined signed ALU with valid/ready handshake, saturation and status flags
module alu_pipe #(
    parameter int WIDTH = 4,
    parameter int OPW   = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPW-1:0]   opcode,
    input  logic             sat_en,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   C,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_v,
    output logic             flag_err
);

    localparam logic [OPW-1:0] OP_ADD   = OPW'(0);
    localparam logic [OPW-1:0] OP_SUB   = OPW'(1);
    localparam logic [OPW-1:0] OP_NOTA  = OPW'(2);
    localparam logic [OPW-1:0] OP_REDOR = OPW'(3);
    localparam logic [OPW-1:0] OP_AND   = OPW'(4);
    localparam logic [OPW-1:0] OP_OR    = OPW'(5);
    localparam logic [OPW-1:0] OP_XOR   = OPW'(6);

    // Clamp limits, already sign-extended to the WIDTH+1 result width
    localparam logic [WIDTH:0] MAX_X = {2'b00, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH:0] MIN_X = {2'b11, {(WIDTH-1){1'b0}}};

    logic             s1_valid;
    logic [OPW-1:0]   s1_op;
    logic             s1_sat;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;

    logic s2_free;
    logic accept;
    logic advance;

    // Stage 2 can take a beat if empty or its current beat leaves this cycle
    assign s2_free  = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_free;
    assign accept   = in_valid && in_ready;
    assign advance  = s1_valid && s2_free;

    // Stage 1 occupancy; an accept overrides a same-cycle advance
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid <= 1'b0;
        end else if (accept) begin
            s1_valid <= 1'b1;
        end else if (advance) begin
            s1_valid <= 1'b0;
        end
    end

    // Stage 1 operand capture; contents are meaningless while s1_valid is low
    always_ff @(posedge clk) begin
        if (accept) begin
            s1_op  <= opcode;
            s1_sat <= sat_en;
            s1_a   <= A;
            s1_b   <= B;
        end
    end

    logic [WIDTH:0] a_x;
    logic [WIDTH:0] b_x;
    logic [WIDTH:0] arith;
    logic           ovf;
    logic [WIDTH:0] res;
    logic           res_v;
    logic           res_err;

    // One extra bit of headroom means the sum never wraps; overflow of the
    // WIDTH-bit range shows up as the top two bits disagreeing
    assign a_x   = {s1_a[WIDTH-1], s1_a};
    assign b_x   = {s1_b[WIDTH-1], s1_b};
    assign arith = (s1_op == OP_SUB) ? (a_x - b_x) : (a_x + b_x);
    assign ovf   = arith[WIDTH] ^ arith[WIDTH-1];

    // Result and flag selection from the stage 1 beat
    always_comb begin
        res     = '0;
        res_v   = 1'b0;
        res_err = 1'b0;
        case (s1_op)
            OP_ADD, OP_SUB: begin
                res   = arith;
                res_v = ovf;
                if (s1_sat && ovf) begin
                    res = arith[WIDTH] ? MIN_X : MAX_X;
                end
            end
            OP_NOTA:  res = ~a_x;
            OP_REDOR: res = {{WIDTH{1'b0}}, |s1_b};
            OP_AND:   res = a_x & b_x;
            OP_OR:    res = a_x | b_x;
            OP_XOR:   res = a_x ^ b_x;
            default:  res_err = 1'b1;
        endcase
    end

    // Stage 2 output register; holds while stalled, drops valid after a handshake
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            C         <= '0;
            flag_z    <= 1'b0;
            flag_n    <= 1'b0;
            flag_v    <= 1'b0;
            flag_err  <= 1'b0;
        end else if (advance) begin
            out_valid <= 1'b1;
            C         <= res;
            flag_z    <= (res == '0);
            flag_n    <= res[WIDTH];
            flag_v    <= res_v;
            flag_err  <= res_err;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - self-checking bench for alu_pipe (WIDTH=4 scoreboard, WIDTH=8 corners)
module tb_alu_pipe;

    typedef struct {
        logic [2:0] op;
        logic       sat;
        int         a;
        int         b;
        int         c;
        logic       z;
        logic       n;
        logic       v;
        logic       e;
    } vec_t;

    typedef struct {
        int   c;
        logic z;
        logic n;
        logic v;
        logic e;
        int   cyc;
        logic lat;
    } sb_t;

    typedef struct {
        int   c;
        logic z;
        logic n;
        logic v;
        logic e;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] opcode;
    logic       sat_en;
    logic [3:0] a4;
    logic [3:0] b4;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] c4;
    logic       flag_z, flag_n, flag_v, flag_err;

    logic       in_valid8;
    logic       in_ready8;
    logic [2:0] opcode8;
    logic       sat_en8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       out_valid8;
    logic       out_ready8;
    logic [8:0] c8;
    logic       flag_z8, flag_n8, flag_v8, flag_err8;

    int checks;
    int failures;
    int cyc;
    int out_count;

    int   exp_c;
    logic exp_z, exp_n, exp_v, exp_e, exp_lat;

    sb_t sb[$];

    alu_pipe #(.WIDTH(4)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .sat_en(sat_en), .A(a4), .B(b4),
        .out_valid(out_valid), .out_ready(out_ready), .C(c4),
        .flag_z(flag_z), .flag_n(flag_n), .flag_v(flag_v), .flag_err(flag_err)
    );

    alu_pipe #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid8), .in_ready(in_ready8),
        .opcode(opcode8), .sat_en(sat_en8), .A(a8), .B(b8),
        .out_valid(out_valid8), .out_ready(out_ready8), .C(c8),
        .flag_z(flag_z8), .flag_n(flag_n8), .flag_v(flag_v8), .flag_err(flag_err8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input int act, input int expv);
        checks = checks + 1;
        if (act != expv) begin
            failures = failures + 1;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic exp_t model(input int w, input logic [2:0] op, input logic sat,
                                   input int a, input int b);
        exp_t m;
        int mx;
        int mn;
        int r;
        mx  = (1 << (w - 1)) - 1;
        mn  = -(1 << (w - 1));
        r   = 0;
        m.v = 1'b0;
        m.e = 1'b0;
        case (op)
            3'd0: r = a + b;
            3'd1: r = a - b;
            3'd2: r = -a - 1;
            3'd3: r = (b != 0) ? 1 : 0;
            3'd4: r = a & b;
            3'd5: r = a | b;
            3'd6: r = a ^ b;
            default: begin r = 0; m.e = 1'b1; end
        endcase
        if (op <= 3'd1) begin
            m.v = (r > mx) || (r < mn);
            if (sat && m.v) r = (r > mx) ? mx : mn;
        end
        m.c = r;
        m.z = (r == 0);
        m.n = (r < 0);
        return m;
    endfunction

    // Monitor: sample everything on the falling edge, between active edges
    initial begin
        logic stall_prev;
        int   held;
        int   exp_ir;
        sb_t  e;
        stall_prev = 1'b0;
        held       = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                sb.delete();
                stall_prev = 1'b0;
            end else begin
                exp_ir = (sb.size() == 2 && out_valid && !out_ready) ? 0 : 1;
                check("in_ready", int'(in_ready), exp_ir);
                if (stall_prev)
                    check("stall_hold", int'({out_valid, c4, flag_z, flag_n, flag_v, flag_err}), held);
                if (out_valid && out_ready) begin
                    out_count = out_count + 1;
                    if (sb.size() == 0) begin
                        check("unexpected_output", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        check("C", int'($signed(c4)), e.c);
                        check("flag_z", int'(flag_z), int'(e.z));
                        check("flag_n", int'(flag_n), int'(e.n));
                        check("flag_v", int'(flag_v), int'(e.v));
                        check("flag_err", int'(flag_err), int'(e.e));
                        if (e.lat) check("latency", cyc - e.cyc, 2);
                    end
                end
                stall_prev = out_valid && !out_ready;
                held = int'({out_valid, c4, flag_z, flag_n, flag_v, flag_err});
                if (in_valid && in_ready)
                    sb.push_back('{exp_c, exp_z, exp_n, exp_v, exp_e, cyc, exp_lat});
            end
        end
    end

    // Called just after a rising edge; returns just after the edge that took the beat
    task automatic send(input logic [2:0] op, input logic sat, input int a, input int b,
                        input int c, input logic z, input logic n, input logic v,
                        input logic e, input logic lat);
        logic took;
        opcode   = op;
        sat_en   = sat;
        a4       = a[3:0];
        b4       = b[3:0];
        exp_c    = c;
        exp_z    = z;
        exp_n    = n;
        exp_v    = v;
        exp_e    = e;
        exp_lat  = lat;
        in_valid = 1'b1;
        took     = 1'b0;
        for (int t = 0; t < 50 && !took; t++) begin
            @(negedge clk);
            if (in_ready) took = 1'b1;
            @(posedge clk);
            #1;
        end
        if (!took) check("accept_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic send_model(input logic [2:0] op, input logic sat, input int a, input int b,
                              input logic lat);
        exp_t m;
        m = model(4, op, sat, a, b);
        send(op, sat, a, b, m.c, m.z, m.n, m.v, m.e, lat);
    endtask

    task automatic drain();
        logic empty;
        empty = 1'b0;
        for (int t = 0; t < 50 && !empty; t++) begin
            @(posedge clk);
            #1;
            if (sb.size() == 0 && !out_valid) empty = 1'b1;
        end
        if (!empty) check("drain_timeout", 0, 1);
    endtask

    task automatic run8(input logic [2:0] op, input logic sat, input int a, input int b,
                        input int c, input logic v);
        opcode8   = op;
        sat_en8   = sat;
        a8        = a[7:0];
        b8        = b[7:0];
        in_valid8 = 1'b1;
        check("in_ready8", int'(in_ready8), 1);
        @(posedge clk);
        #1;
        in_valid8 = 1'b0;
        @(posedge clk);
        #1;
        check("out_valid8", int'(out_valid8), 1);
        check("C8", int'($signed(c8)), c);
        check("flag_v8", int'(flag_v8), int'(v));
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[18];
    bit   pat[4];

    initial begin
        int   oc0;
        logic bp_done;
        tbl[0]  = '{3'd0, 1'b0,  7,  7,  14, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[1]  = '{3'd0, 1'b0, -8, -8, -16, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[2]  = '{3'd1, 1'b0,  7, -8,  15, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[3]  = '{3'd1, 1'b0, -8,  7, -15, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[4]  = '{3'd0, 1'b0,  7, -8,  -1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{3'd0, 1'b1,  7,  7,   7, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[6]  = '{3'd1, 1'b1, -8,  7,  -8, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[7]  = '{3'd0, 1'b1,  3,  2,   5, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{3'd2, 1'b0,  0,  0,  -1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{3'd2, 1'b1,  7,  0,  -8, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{3'd2, 1'b0, -8,  0,   7, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{3'd3, 1'b0,  5,  0,   0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{3'd3, 1'b0,  0, -8,   1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[13] = '{3'd4, 1'b0,  5,  3,   1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[14] = '{3'd5, 1'b0,  5,  3,   7, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[15] = '{3'd6, 1'b0,  5,  3,   6, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[16] = '{3'd7, 1'b0,  3,  3,   0, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[17] = '{3'd4, 1'b1, -8, -1,  -8, 1'b0, 1'b1, 1'b0, 1'b0};
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;

        checks    = 0;
        failures  = 0;
        out_count = 0;
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        opcode    = 3'd0;
        sat_en    = 1'b0;
        a4        = 4'd0;
        b4        = 4'd0;
        in_valid8 = 1'b0;
        out_ready8 = 1'b1;
        opcode8   = 3'd0;
        sat_en8   = 1'b0;
        a8        = 8'd0;
        b8        = 8'd0;
        exp_c = 0; exp_z = 1'b0; exp_n = 1'b0; exp_v = 1'b0; exp_e = 1'b0; exp_lat = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_C", int'(c4), 0);
        check("rst_flags", int'({flag_z, flag_n, flag_v, flag_err}), 0);
        check("rst_in_ready", int'(in_ready), 1);
        reset = 1'b1;

        // Table vectors, back to back with no backpressure
        for (int i = 0; i < 18; i++)
            send(tbl[i].op, tbl[i].sat, tbl[i].a, tbl[i].b, tbl[i].c,
                 tbl[i].z, tbl[i].n, tbl[i].v, tbl[i].e, 1'b1);
        drain();

        // Backpressure: 8 random beats while out_ready follows 1,0,0,1
        oc0 = out_count;
        bp_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send_model(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                               int'($urandom_range(0, 15)) - 8, int'($urandom_range(0, 15)) - 8, 1'b0);
                bp_done = 1'b1;
            end
            begin
                for (int k = 0; !bp_done; k++) begin
                    out_ready = pat[k % 4];
                    @(posedge clk);
                    #1;
                end
            end
        join
        out_ready = 1'b1;
        drain();
        check("bp_delivered", out_count - oc0, 8);

        // Reset with two beats in flight
        out_ready = 1'b0;
        send_model(3'd0, 1'b0, 1, 2, 1'b0);
        send_model(3'd1, 1'b0, 3, 1, 1'b0);
        check("pre_rst_out_valid", int'(out_valid), 1);
        reset = 1'b0;
        #1;
        check("mid_rst_out_valid", int'(out_valid), 0);
        check("mid_rst_C", int'(c4), 0);
        check("mid_rst_in_ready", int'(in_ready), 1);
        repeat (2) @(posedge clk);
        #1;
        oc0 = out_count;
        reset = 1'b1;
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("dropped_beats", out_count - oc0, 0);
        check("post_rst_in_ready", int'(in_ready), 1);
        send_model(3'd0, 1'b0, 3, 2, 1'b1);
        drain();
        check("post_rst_one_beat", out_count - oc0, 1);

        // WIDTH=8 arithmetic corners
        run8(3'd0, 1'b0,  127,  127,  254, 1'b1);
        run8(3'd1, 1'b0, -128,  127, -255, 1'b1);
        run8(3'd0, 1'b1,  127,  127,  127, 1'b1);
        run8(3'd1, 1'b1, -128,  127, -128, 1'b1);
        run8(3'd0, 1'b0,  100,  -50,   50, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, two-stage pipelined signed ALU; successor to the 4-bit registered ALU.
- Generalises operand width and opcode set.
- Adds valid/ready handshakes on input and output, optional saturation, and status flags (zero, negative, overflow, illegal-opcode).
- Sits between the operand scheduler (upstream) and the result writeback/consumer (downstream).

Parameters:
WIDTH, 4, operand width in bits, two's complement; legal range is 2 to 32.
OPW, 3, opcode width; fixed at 3, exposed for testbench use.

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset; 0 = reset asserted
in_valid  in  1  operand beat valid
in_ready  out  1  block can accept operand beat
opcode  in  3  operation select
sat_en  in  1  saturate ADD/SUB results to WIDTH-bit range
A  in  WIDTH  signed operand A
B  in  WIDTH  signed operand B
out_valid  out  1  result beat valid
out_ready  in  1  downstream accepts result
C  out  WIDTH+1  signed result
flag_z  out  1  C == 0
flag_n  out  1  C[WIDTH] (sign bit)
flag_v  out  1  ADD/SUB true result outside WIDTH-bit signed range
flag_err  out  1  illegal opcode

Behaviour:
- Opcodes:
  - 000 ADD: C = A + B, full WIDTH+1 precision.
  - 001 SUB: C = A - B.
  - 010 NOT_A: C = sign-extended ~A.
  - 011 REDOR_B: C = zero-extended |B.
  - 100 AND, 101 OR, 110 XOR: bitwise result, sign-extended.
  - 111: illegal; C = 0, flag_err = 1.
- Arithmetic is performed in WIDTH+1 bits after sign-extending both operands; it never wraps.
- flag_v is set only for ADD/SUB, when the true result is greater than 2^(WIDTH-1)-1 or less than -2^(WIDTH-1). flag_v is 0 for all other opcodes.
- sat_en = 1 on ADD/SUB: C is clamped to 2^(WIDTH-1)-1 or -2^(WIDTH-1), then sign-extended to WIDTH+1. flag_v still reports the overflow. sat_en has no effect on other opcodes.
- Pipeline:
  - Stage 1 registers opcode, sat_en, A and B on an accepted beat (in_valid && in_ready).
  - Stage 2 registers C and the flags computed from stage 1.
- Handshake:
  - s2_free = !out_valid || out_ready.
  - s1 advances when s1_valid && s2_free.
  - in_ready = !s1_valid || s2_free. in_ready is combinational from out_ready; no combinational path from in_valid.
- Latency: an accepted beat appears on out_valid exactly 2 cycles later when there is no backpressure. Throughput is 1 beat/cycle under continuous out_ready.
- Backpressure:
  - While out_valid && !out_ready, C, all flags and out_valid hold stable.
  - Stage 1 holds its beat; in_ready drops once stage 1 is occupied.
  - No beat is lost or duplicated.
- Simultaneous events:
  - out_ready = 1 with a full pipeline: the output beat and a new input beat transfer in the same cycle.
  - out_valid may deassert only after a handshake completes.
- Ordering: results leave in acceptance order.
- Reset (reset = 0, any time, asynchronous):
  - s1_valid = 0, out_valid = 0, C = 0, all flags = 0.
  - in_ready reads 1 while reset is asserted and after release.
  - In-flight beats are discarded.
  - The first acceptance occurs on the first rising edge with reset = 1.
- Data registers need no reset except C and the flags. When out_valid = 0, C and the flags are don't-care for checking.

Test Plan:
- Reset, WIDTH=4: drive reset = 0 mid-stream with 2 beats in flight -> out_valid = 0 and C = 0 immediately; after release the dropped beats never appear and in_ready = 1.
- Arithmetic corners, WIDTH=4, sat_en = 0, out_ready = 1:
  - ADD 7+7 -> C = 14, flag_v = 1.
  - ADD -8+-8 -> C = -16, flag_n = 1, flag_v = 1.
  - SUB 7-(-8) -> C = 15, flag_v = 1.
  - SUB -8-7 -> C = -15.
  - ADD 7+(-8) -> C = -1, flag_v = 0.
  - Each result arrives 2 cycles after acceptance.
- Saturation, sat_en = 1:
  - ADD 7+7 -> C = 7, flag_v = 1.
  - SUB -8-7 -> C = -8, flag_v = 1.
  - ADD 3+2 -> C = 5, flag_v = 0.
- Logic ops:
  - NOT_A with A = 0 -> C = -1; A = 7 -> C = -8; A = -8 -> C = 7.
  - REDOR_B with B = 0 -> C = 0, flag_z = 1; B = -8 -> C = 1.
  - AND 0101 & 0011 -> C = 1.
  - opcode 111 -> C = 0, flag_err = 1, flag_z = 1.
- Backpressure: stream 8 back-to-back beats while out_ready toggles 1,0,0,1,... -> all 8 results in order with C stable while stalled; in_ready = 0 only when both stages are full and out_ready = 0.
- Parametrisation: rerun the arithmetic-corner scenario at WIDTH=8:
  - ADD 127+127 -> 254.
  - SUB -128-127 -> -255.
  - Same with sat_en = 1 -> 127 and -128.
